// File: rtl/lcs_pkg.sv
// Shared types for the lcs loader: FSM states, error codes and character normalisation.
package lcs_pkg;

  typedef enum logic [2:0] {
    LOAD0,
    LOAD1,
    START,
    RUN,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CHAR = 2'd1,
    ERR_OVF  = 2'd2
  } err_code_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] ch;
  } norm_t;

  // Accepts A/C/G/T in either case and returns the upper-case form.
  function automatic norm_t normalise(input logic [7:0] c);
    norm_t r;
    r.valid = 1'b1;
    r.ch    = c;
    case (c)
      8'h41, 8'h43, 8'h47, 8'h54: r.ch = c;
      8'h61, 8'h63, 8'h67, 8'h74: r.ch = c & 8'hdf;
      default:                    r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcs_seq_buf.sv
// Sequence buffer: one write port, one BRAM-style registered read port.
module lcs_seq_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_reg;

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read with one-cycle latency; holds when not enabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rd_data_reg <= 8'h00;
    else if (rd_en) rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/lcs_seq_loader.sv
// Loads two DNA sequences from a byte stream, serves them to lcs and runs the start/done handshake.
module lcs_seq_loader
  import lcs_pkg::*;
#(
  parameter int MAX_SEQ = 8,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  output logic          lcs_start,
  input  logic          lcs_ready,
  input  logic          lcs_done,
  output logic [31:0]   lcs_n,
  output logic [31:0]   lcs_m,
  input  logic [AW-1:0] mem_address0,
  input  logic          mem_ce0,
  output logic [7:0]    mem_q0,
  output logic          job_done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int CW = $clog2(MAX_SEQ + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_SEQ);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   n_reg, n_next;
  logic [CW-1:0]   m_reg, m_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [1:0]      drain_reg, drain_next;
  logic [31:0]     lcs_n_reg, lcs_n_next;
  logic [31:0]     lcs_m_reg, lcs_m_next;
  logic            err_reg, err_next;
  err_code_t       err_code_reg, err_code_next;
  logic            job_done_reg, job_done_next;
  logic            active_reg;

  norm_t           norm;
  logic            beat;
  logic            wr_en;
  logic            in_seq1;
  logic [CW-1:0]   cur_len;
  logic [CW-1:0]   m_inc;
  logic [1:0]      open_cnt;

  assign norm = normalise(s_data);
  // s_ready stays low until the first clock after reset release.
  assign s_ready   = active_reg && (state_reg == LOAD0 || state_reg == LOAD1 || state_reg == DRAIN);
  assign beat      = s_valid && s_ready;
  assign lcs_start = (state_reg == START);
  assign lcs_n     = lcs_n_reg;
  assign lcs_m     = lcs_m_reg;
  assign job_done  = job_done_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;

  // Next-state and datapath decisions for loading, handshake and error draining.
  always_comb begin
    state_next    = state_reg;
    n_next        = n_reg;
    m_next        = m_reg;
    wr_ptr_next   = wr_ptr_reg;
    drain_next    = drain_reg;
    lcs_n_next    = lcs_n_reg;
    lcs_m_next    = lcs_m_reg;
    err_next      = 1'b0;
    err_code_next = err_code_reg;
    job_done_next = 1'b0;
    wr_en         = 1'b0;
    in_seq1       = (state_reg == LOAD1);
    cur_len       = in_seq1 ? m_reg : n_reg;
    m_inc         = m_reg + CNT_ONE;
    open_cnt      = (in_seq1 ? 2'd1 : 2'd2) - {1'b0, s_last};
    case (state_reg)
      LOAD0, LOAD1: begin
        if (beat) begin
          if (!norm.valid || cur_len == CNT_MAX) begin
            // Drop the job; the offending beat's own s_last closes its sequence.
            err_next      = 1'b1;
            err_code_next = !norm.valid ? ERR_CHAR : ERR_OVF;
            n_next        = '0;
            m_next        = '0;
            wr_ptr_next   = '0;
            drain_next    = open_cnt;
            state_next    = (open_cnt == 2'd0) ? LOAD0 : DRAIN;
          end else begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (in_seq1) m_next = m_inc;
            else         n_next = n_reg + CNT_ONE;
            if (s_last) begin
              if (in_seq1) begin
                lcs_n_next = {{(32-CW){1'b0}}, n_reg};
                lcs_m_next = {{(32-CW){1'b0}}, m_inc};
                state_next = START;
              end else begin
                state_next = LOAD1;
              end
            end
          end
        end
      end
      START: begin
        if (lcs_ready) begin
          if (lcs_done) begin
            job_done_next = 1'b1;
            n_next        = '0;
            m_next        = '0;
            wr_ptr_next   = '0;
            state_next    = LOAD0;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (lcs_done) begin
          job_done_next = 1'b1;
          n_next        = '0;
          m_next        = '0;
          wr_ptr_next   = '0;
          state_next    = LOAD0;
        end
      end
      DRAIN: begin
        if (beat && s_last) begin
          drain_next = drain_reg - 2'd1;
          if (drain_reg == 2'd1) state_next = LOAD0;
        end
      end
      default: state_next = LOAD0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= LOAD0;
      n_reg        <= '0;
      m_reg        <= '0;
      wr_ptr_reg   <= '0;
      drain_reg    <= '0;
      lcs_n_reg    <= '0;
      lcs_m_reg    <= '0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
      job_done_reg <= 1'b0;
      active_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      n_reg        <= n_next;
      m_reg        <= m_next;
      wr_ptr_reg   <= wr_ptr_next;
      drain_reg    <= drain_next;
      lcs_n_reg    <= lcs_n_next;
      lcs_m_reg    <= lcs_m_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
      job_done_reg <= job_done_next;
      active_reg   <= 1'b1;
    end
  end

  lcs_seq_buf #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_buf (
    .clk    (clk),
    .rstn   (rstn),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_reg),
    .wr_data(norm.ch),
    .rd_en  (mem_ce0),
    .rd_addr(mem_address0),
    .rd_data(mem_q0)
  );

endmodule

// File: doc/lcs_seq_loader.md
Name: lcs_seq_loader

Overview:
- Upstream stage of the lcs HLS core.
- Accepts two DNA sequences as a byte stream with valid/ready handshake, validates and normalises the characters, and packs them into a local concatenated buffer {seq0, seq1}.
- Serves that buffer to lcs through its single-port read interface (address0/ce0/q0), drives lcs n/m, and sequences the ap_start/ap_ready/ap_done handshake once per job.

Parameters:
- MAX_SEQ, 8, maximum characters per sequence.
- DEPTH, 16, buffer bytes; must be >= 2*MAX_SEQ.
- AW, 4, buffer address width, clog2(DEPTH).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- s_valid  in  1  input character valid
- s_ready  out  1  loader can accept a character
- s_data  in  8  ASCII character
- s_last  in  1  character is the last of the current sequence
- lcs_start  out  1  to lcs ap_start
- lcs_ready  in  1  from lcs ap_ready
- lcs_done  in  1  from lcs ap_done
- lcs_n  out  32  seq0 length, to lcs n
- lcs_m  out  32  seq1 length, to lcs m
- mem_address0  in  AW  from lcs data_in_address0
- mem_ce0  in  1  from lcs data_in_ce0
- mem_q0  out  8  to lcs data_in_q0
- job_done  out  1  one-cycle pulse when lcs completes a job
- err  out  1  one-cycle pulse when a job is dropped
- err_code  out  2  0 none, 1 bad char, 2 overflow; held until the next err

Behaviour:
- Reset values:
  - s_ready=0, lcs_start=0, lcs_n=0, lcs_m=0, mem_q0=0, job_done=0, err=0, err_code=0.
  - FSM in LOAD0; write pointer and length counters 0.
  - Buffer contents are not reset.
- Transfer: a character is accepted on a posedge with s_valid && s_ready.
- Normalisation:
  - 'a','c','g','t' are converted to upper case.
  - 'A','C','G','T' are stored unchanged.
  - Any other byte is a bad character (err_code=1).
- Write address = running count of accepted characters. seq0 occupies 0..n-1; seq1 occupies n..n+m-1.
- FSM states:
  - LOAD0: s_ready=1; store each character and increment n. When the accepted beat has s_last, go to LOAD1.
  - LOAD1: s_ready=1; store each character and increment m. When the accepted beat has s_last, latch lcs_n/lcs_m and go to START.
  - START: s_ready=0; lcs_start=1. Held until a posedge with lcs_ready=1, then lcs_start drops next cycle and the FSM goes to RUN.
  - RUN: s_ready=0; wait for lcs_done. On lcs_done: job_done pulses, counters clear, go to LOAD0.
  - DRAIN: s_ready=1; discard beats until the remaining s_last count reaches 0. Then go to LOAD0 with counters cleared.
- Errors:
  - Overflow: a character that would make the current sequence exceed MAX_SEQ sets err_code=2.
  - Bad character or overflow: err pulses on the cycle after the offending beat and nothing more is written.
  - If the offending beat itself has s_last, the sequence counts as closed.
  - DRAIN s_last count = sequences still open: 2 if the error occurred in LOAD0, 1 if in LOAD1, minus 1 if the offending beat had s_last. If that count is 0, go straight to LOAD0.
- Read port:
  - mem_q0 <= buf[mem_address0] on posedge when mem_ce0=1, else mem_q0 holds (1-cycle latency, same timing as a BRAM).
  - Reads are honoured in every state.
  - Addresses >= n+m return stale buffer contents; lcs never issues them.
- Simultaneous events:
  - lcs_ready and lcs_done on the same posedge in START: take the RUN exit directly (job_done pulses, go to LOAD0).
  - lcs_done outside RUN is ignored.
- Widths: n and m counters are clog2(MAX_SEQ+1) bits, zero-extended onto lcs_n/lcs_m.
- Reset asserted mid-job: all outputs return to reset values immediately (asynchronous). Any job in flight is abandoned; the lcs instance shares the same reset.

Decomposition:
- Package lcs_pkg holds:
  - the FSM state enum (LOAD0, LOAD1, START, RUN, DRAIN);
  - the err_code enum (ERR_NONE, ERR_CHAR, ERR_OVF);
  - a function is_dna_char/normalise(byte) returning the upper-case character plus a valid bit.
- One sub-module, lcs_seq_buf: DEPTH x 8 memory with one write port and one registered read port (mem_q0 register inside).

Test Plan:
1. Stream "ATCTGAT" (s_last on the final 'T'), then "TGCATA" -> lcs_n=7, lcs_m=6, buffer holds "ATCTGATTGCATA". lcs_start rises the cycle after the last beat and falls after lcs_ready. With the real lcs core, the output buffer reads "TCTA" and job_done pulses once.
2. Stream "atctgat"/"tgcata" -> identical buffer and result to scenario 1 (lower case normalised).
3. Stream "ATXG" (s_last on G), then "TGCA" -> err pulses with err_code=1. DRAIN consumes through the s_last of "TGCA" (count 2, minus the s_last still pending), lcs_start never asserts, FSM back in LOAD0 with s_ready=1.
4. seq0 of 9 characters, MAX_SEQ=8 -> err_code=2 on the 9th beat. Loader drains to the second s_last; a following valid job then runs normally.
5. Hold lcs_ready low for 5 cycles in START -> lcs_start stays high for exactly those cycles and s_ready stays 0. Pulse lcs_done in LOAD0 -> no effect.
6. Deassert rstn during RUN -> lcs_start=0, s_ready=0 asynchronously. After release: LOAD0, s_ready=1, and a new job from scenario 1 passes.
